// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR random-number scheduler: tap masks, FSM states, default seed.
package lfsr_pkg;

  typedef enum logic {ST_WARMUP, ST_SERVE} state_t;

  localparam logic [7:0] DEFAULT_SEED = 8'h01;

  // Maximal-length Fibonacci taps; bit i set means q[i] feeds the XOR.
  function automatic logic [7:0] lfsr_taps(input int w);
    case (w)
      3:       return 8'b0000_0110;
      4:       return 8'b0000_1100;
      5:       return 8'b0001_0100;
      6:       return 8'b0011_0000;
      7:       return 8'b0110_0000;
      8:       return 8'b1011_1000;
      default: return 8'b0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register: shifts left, new bit0 is the XOR of the tapped bits.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  localparam logic [7:0]       TAPS8 = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS  = TAPS8[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= SEED;
    else if (load) q <= load_val;
    else if (step) q <= {q[WIDTH-2:0], ^(q & TAPS)};
  end

endmodule

// File: rtl/lfsr_rng_sched.sv
// Round-robin scheduler handing out one fresh LFSR value per grant, with seed load and warm-up.
//   state     | meaning
//   ST_WARMUP | LFSR steps every cycle, requests ignored, counter runs 0..WARMUP-1
//   ST_SERVE  | one grant per cycle when any req is set; LFSR steps only on a grant
module lfsr_rng_sched
  import lfsr_pkg::*;
#(
  parameter int               NREQ   = 4,
  parameter int               WIDTH  = 4,
  parameter logic [WIDTH-1:0] SEED   = DEFAULT_SEED[WIDTH-1:0],
  parameter int               WARMUP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_val,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic             rnd_valid,
  output logic [WIDTH-1:0] rnd_data,
  output logic             rnd_ready
);

  localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int PW = $clog2(NREQ);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic              cnt_last;
  logic [PW-1:0]     ptr, ptr_nxt;
  logic [NREQ-1:0]   gnt_nxt;
  logic              found, grant_en, lfsr_step;
  logic [WIDTH-1:0]  lfsr_q, load_val;

  assign cnt_last = (cnt == CW'(WARMUP - 1));
  assign load_val = (seed_val == '0) ? SEED : seed_val;

  lfsr_core #(.WIDTH(WIDTH), .SEED(SEED)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_load),
    .load_val (load_val),
    .step     (lfsr_step),
    .q        (lfsr_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_WARMUP;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (seed_load)              cnt <= '0;
      else if (state == ST_WARMUP) cnt <= cnt_last ? '0 : cnt + CW'(1);
      if (grant_en) ptr <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (seed_load)                             state_nxt = ST_WARMUP;
    else if (state == ST_WARMUP && cnt_last)   state_nxt = ST_SERVE;
  end

  always_comb begin
    rnd_ready = (state == ST_SERVE);
    grant_en  = (state == ST_SERVE) && !seed_load && found;
    lfsr_step = !seed_load && ((state == ST_WARMUP) || grant_en);
  end

  // First set req at or after ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_nxt = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found                            = 1'b1;
        gnt_nxt[(int'(ptr) + k) % NREQ]  = 1'b1;
        ptr_nxt                          = PW'((int'(ptr) + k + 1) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
    end else begin
      gnt       <= grant_en ? gnt_nxt : '0;
      rnd_valid <= grant_en;
      rnd_data  <= grant_en ? lfsr_q : '0;
    end
  end

endmodule
